norm_result_sink: RTL and testbench

Receiving end of the Euclidean-norm accumulator's result interface. Captures each 10-bit norm result presented with its valid strobe, buffers it in a small first-word-fall-through FIFO, and hands it downstream over a ready/valid handshake. The producer has no backpressure, so the sink reports dropped results through a sticky overflow flag.

---
 rtl/norm_pkg.sv | 9 +
 rtl/norm_sink_fifo.sv | 62 ++++++
 rtl/norm_result_sink.sv | 75 +++++++
 tb/tb_norm_result_sink.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/norm_pkg.sv
// Shared types and widths for the Euclidean-norm datapath and its result sink.
package norm_pkg;

    localparam int G_W = 10;
    localparam int A_W = 8;

    typedef logic [G_W-1:0] norm_t;

endpackage

// File: rtl/norm_sink_fifo.sv
// First-word-fall-through FIFO for norm results: storage, pointers, occupancy.
// The caller decides push/pop legality; this block only tracks state.
module norm_sink_fifo
    import norm_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  norm_t            wdata_i,
    output norm_t            rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    norm_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that skips one infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_i && !pop_i)
            count_d = count_q + CNT_W'(1);
        else if (pop_i && !push_i)
            count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; rdata_o is masked to zero whenever count is zero.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/norm_result_sink.sv
// Result sink for the norm accumulator: FWFT buffer, sticky overflow on drops,
// optional running maximum of accepted results (enabled by NORM_SINK_MAX_EN).
module norm_result_sink
    import norm_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  norm_t            g_in,
    output norm_t            out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             overflow,
    input  logic             clr_ovf
`ifdef NORM_SINK_MAX_EN
    ,
    output norm_t            max_g
`endif
);

    logic empty;
    logic push;
    logic pop;
    logic drop;
    logic overflow_q;

    assign pop  = !empty && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push = valid_in && (!full || pop);
    assign drop = valid_in && !push;

    norm_sink_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (g_in),
        .rdata_o (out_data),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign out_valid = !empty;

    always_ff @(posedge clk) begin
        if (!reset)
            overflow_q <= 1'b0;
        else if (clr_ovf)
            overflow_q <= 1'b0;
        else if (drop)
            overflow_q <= 1'b1;
    end

    assign overflow = overflow_q;

`ifdef NORM_SINK_MAX_EN
    norm_t max_g_q;

    always_ff @(posedge clk) begin
        if (!reset)
            max_g_q <= '0;
        else if (push && (g_in > max_g_q))
            max_g_q <= g_in;
    end

    assign max_g = max_g_q;
`endif

endmodule

// File: tb/tb_norm_result_sink.sv
// Self-checking bench for norm_result_sink: directed vector table, then random
// traffic against a queue-based reference model.
module tb_norm_result_sink;
    import norm_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid_in;
    norm_t            g_in;
    norm_t            out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             overflow;
    logic             clr_ovf;
`ifdef NORM_SINK_MAX_EN
    norm_t            max_g;
`endif

    norm_result_sink #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .g_in      (g_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef NORM_SINK_MAX_EN
        ,
        .max_g     (max_g)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst_n;
        bit vld;
        int g;
        bit rdy;
        bit clr;
        int e_count;
        int e_data;
        bit e_valid;
        bit e_full;
        bit e_ovf;
        int e_max;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    int   mq[$];
    int   m_ovf;
    int   m_max;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic void add(bit r, bit v, int g, bit rdy, bit clr,
                                int ec, int ed, bit ev, bit ef, bit eo, int em);
        vec_t t;
        t = '{r, v, g, rdy, clr, ec, ed, ev, ef, eo, em};
        vecs.push_back(t);
    endfunction

    task automatic drive_and_clock(bit r, bit v, int g, bit rdy, bit clr);
        reset     = r;
        valid_in  = v;
        g_in      = norm_t'(g);
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(string tag, int ec, int ed, bit ev, bit ef, bit eo, int em);
        check({tag, " count"},     int'(count),     ec);
        check({tag, " out_data"},  int'(out_data),  ed);
        check({tag, " out_valid"}, int'(out_valid), int'(ev));
        check({tag, " full"},      int'(full),      int'(ef));
        check({tag, " overflow"},  int'(overflow),  int'(eo));
`ifdef NORM_SINK_MAX_EN
        check({tag, " max_g"},     int'(max_g),     em);
`endif
    endtask

    // Applies the FIFO rules directly: head leaves first, then a new value
    // joins if there is room for it after that.
    function automatic void model_step(bit r, bit v, int g, bit rdy, bit clr);
        bit popped;
        bit accepted;
        if (!r) begin
            mq.delete();
            m_ovf = 0;
            m_max = 0;
            return;
        end
        popped   = (mq.size() > 0) && rdy;
        accepted = v && ((mq.size() < DEPTH) || popped);
        if (popped) void'(mq.pop_front());
        if (accepted) begin
            mq.push_back(g);
            if (g > m_max) m_max = g;
        end
        if (clr) m_ovf = 0;
        else if (v && !accepted) m_ovf = 1;
    endfunction

    initial begin
        reset = 1'b0; valid_in = 1'b0; g_in = '0; out_ready = 1'b0; clr_ovf = 1'b0;

        //    rst v  g    rdy clr  cnt data vld full ovf max
        add(0, 0, 0,    0, 0,   0,  0,  0, 0, 0,  0);   // reset
        add(1, 1, 21,   0, 0,   1, 21,  1, 0, 0, 21);   // one-cycle capture latency
        add(1, 0, 0,    1, 0,   0,  0,  0, 0, 0, 21);
        add(1, 1, 21,   0, 0,   1, 21,  1, 0, 0, 21);   // 21, 41, 76 then drain
        add(1, 1, 41,   0, 0,   2, 21,  1, 0, 0, 41);
        add(1, 1, 76,   0, 0,   3, 21,  1, 0, 0, 76);
        add(1, 0, 0,    1, 0,   2, 41,  1, 0, 0, 76);
        add(1, 0, 0,    1, 0,   1, 76,  1, 0, 0, 76);
        add(1, 0, 0,    1, 0,   0,  0,  0, 0, 0, 76);
        add(1, 1, 1,    0, 0,   1,  1,  1, 0, 0, 76);   // five pushes, no drain
        add(1, 1, 2,    0, 0,   2,  1,  1, 0, 0, 76);
        add(1, 1, 3,    0, 0,   3,  1,  1, 0, 0, 76);
        add(1, 1, 4,    0, 0,   4,  1,  1, 1, 0, 76);
        add(1, 1, 500,  0, 0,   4,  1,  1, 1, 1, 76);   // dropped
        add(1, 0, 0,    0, 1,   4,  1,  1, 1, 0, 76);   // clear overflow
        add(1, 1, 99,   1, 0,   4,  2,  1, 1, 0, 99);   // push+pop while full
        add(1, 0, 0,    1, 0,   3,  3,  1, 0, 0, 99);
        add(1, 0, 0,    1, 0,   2,  4,  1, 0, 0, 99);
        add(1, 0, 0,    1, 0,   1, 99,  1, 0, 0, 99);   // 99 was the tail
        add(1, 0, 0,    1, 0,   0,  0,  0, 0, 0, 99);
        add(1, 1, 10,   0, 0,   1, 10,  1, 0, 0, 99);
        add(1, 1, 11,   0, 0,   2, 10,  1, 0, 0, 99);
        add(1, 1, 12,   0, 0,   3, 10,  1, 0, 0, 99);
        add(1, 1, 13,   0, 0,   4, 10,  1, 1, 0, 99);
        add(1, 1, 14,   0, 1,   4, 10,  1, 1, 0, 99);   // clr wins over drop
        add(1, 1, 15,   0, 0,   4, 10,  1, 1, 1, 99);
        add(0, 1, 7,    0, 0,   0,  0,  0, 0, 0,  0);   // reset mid-stream, valid ignored
        add(1, 1, 50,   1, 0,   1, 50,  1, 0, 0, 50);   // empty: no bypass
        add(1, 0, 0,    1, 0,   0,  0,  0, 0, 0, 50);
        add(0, 0, 0,    0, 0,   0,  0,  0, 0, 0,  0);
        add(1, 1, 41,   0, 0,   1, 41,  1, 0, 0, 41);   // running max
        add(1, 1, 76,   0, 0,   2, 41,  1, 0, 0, 76);
        add(1, 1, 21,   0, 0,   3, 41,  1, 0, 0, 76);
        add(1, 1, 1,    0, 0,   4, 41,  1, 1, 0, 76);
        add(1, 1, 1023, 0, 0,   4, 41,  1, 1, 1, 76);   // dropped, max unchanged
        add(0, 1, 5,    0, 0,   0,  0,  0, 0, 0,  0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_and_clock(vecs[i].rst_n, vecs[i].vld, vecs[i].g, vecs[i].rdy, vecs[i].clr);
            check_outputs($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_data,
                          vecs[i].e_valid, vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_max);
        end

        // Random traffic against the reference model.
        model_step(0, 0, 0, 0, 0);
        drive_and_clock(0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit r, v, rdy, clr;
            int g;
            r   = ($urandom_range(0, 255) != 0);
            v   = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 1) != 0);
            clr = ($urandom_range(0, 15) == 0);
            g   = int'($urandom_range(0, 1023));
            model_step(r, v, g, rdy, clr);
            drive_and_clock(r, v, g, rdy, clr);
            check_outputs($sformatf("rnd%0d", i), mq.size(),
                          (mq.size() > 0) ? mq[0] : 0, mq.size() > 0,
                          mq.size() == DEPTH, m_ovf[0], m_max);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
